// File: rtl/alu_seq_control.sv
// -----------------------------------------------------------------------------
// alu_seq_control
//
// Hardwired control unit for the 32-bit datapath. It walks the datapath
// through instruction fetch (T0..T2, with T1W stretching the memory read) and
// register-register execute (T3..T6). Every state drives exactly one clock
// cycle of datapath strobes.
//
// Ports
//   Clock     in   system clock, rising edge
//   Clear     in   asynchronous active-high reset
//   IR        in   instruction register, opcode = IR[31:27]
//   MemDone   in   memory read data valid this cycle
//   Stop      in   halt request, only honoured in T0
//   PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin     fetch strobes
//   Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin      ALU/result strobes
//   Gra, Grb, Grc, Rin, Rout                                 register selects
//   OP        out  ALU operation code (zero outside T4)
//   Run       out  high while sequencing (T0..T6)
//   Illegal   out  sticky unsupported-opcode flag
//   Timeout   out  sticky memory-wait overflow flag
//   State     out  current FSM state code, for observation
//
// Handshake: the memory read is a plain level handshake. Read/MDRin are held
// from T1 through T1W; the cycle in which MemDone is sampled high is the last
// read cycle and the FSM moves to T2 on the following edge. There is no
// back-pressure in the other direction.
// -----------------------------------------------------------------------------
module alu_seq_control #(
   parameter int OPW          = 5,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic           Clock,
   input  logic           Clear,
   input  logic [31:0]    IR,
   input  logic           MemDone,
   input  logic           Stop,
   output logic           PCout,
   output logic           MARin,
   output logic           IncPC,
   output logic           PCin,
   output logic           Read,
   output logic           MDRin,
   output logic           MDRout,
   output logic           IRin,
   output logic           Yin,
   output logic           ZLowin,
   output logic           ZHighin,
   output logic           ZLowout,
   output logic           ZHighout,
   output logic           HIin,
   output logic           LOin,
   output logic           Gra,
   output logic           Grb,
   output logic           Grc,
   output logic           Rin,
   output logic           Rout,
   output logic [OPW-1:0] OP,
   output logic           Run,
   output logic           Illegal,
   output logic           Timeout,
   output logic [3:0]     State
);

   typedef enum logic [3:0] {
      S_RST  = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T1W  = 4'd3,
      S_T2   = 4'd4,
      S_T3   = 4'd5,
      S_T4   = 4'd6,
      S_T5   = 4'd7,
      S_T6   = 4'd8,
      S_HALT = 4'd9
   } state_t;

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);
   // Value of the wait counter during the last permitted T1W cycle.
   localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

   localparam logic [OPW-1:0] OPC_ALU_LO = OPW'(5'b00011);
   localparam logic [OPW-1:0] OPC_ALU_HI = OPW'(5'b01011);
   localparam logic [OPW-1:0] OPC_MUL    = OPW'(5'b01111);
   localparam logic [OPW-1:0] OPC_DIV    = OPW'(5'b10000);
   localparam logic [OPW-1:0] OPC_NOP    = OPW'(5'b11010);
   localparam logic [OPW-1:0] OPC_HALT   = OPW'(5'b11011);

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt;

   // ---------------------------------------------------------------------------
   // Opcode decode. Register fields are routed by the select-and-encode logic
   // downstream; only the opcode matters here.
   // ---------------------------------------------------------------------------
   logic [OPW-1:0] opcode;
   logic           is_alu;
   logic           is_muldiv;
   logic           is_exec;
   logic           is_nop;
   logic           is_halt;
   logic           unused_ir_fields;

   assign opcode    = IR[31:32-OPW];
   assign is_alu    = (opcode >= OPC_ALU_LO) && (opcode <= OPC_ALU_HI);
   assign is_muldiv = (opcode == OPC_MUL) || (opcode == OPC_DIV);
   assign is_exec   = is_alu || is_muldiv;
   assign is_nop    = (opcode == OPC_NOP);
   assign is_halt   = (opcode == OPC_HALT);
   assign unused_ir_fields = &{1'b0, IR[31-OPW:0]};

   // Conditions that set the sticky flags, shared by next-state and flag logic.
   logic mem_expire;
   logic bad_opcode;

   assign mem_expire = (state == S_T1W) && !MemDone && (wait_cnt == WAIT_LAST);
   assign bad_opcode = (state == S_T3) && !is_exec && !is_nop && !is_halt;

   // ---------------------------------------------------------------------------
   // State, wait counter and sticky flags
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state    <= S_RST;
         wait_cnt <= '0;
         Illegal  <= 1'b0;
         Timeout  <= 1'b0;
      end else begin
         state <= state_nxt;

         // Counter only runs while stretched in T1W; it is zero on entry.
         if (state == S_T1W && !MemDone && !mem_expire) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end

         if (bad_opcode) Illegal <= 1'b1;
         if (mem_expire) Timeout <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_RST:  state_nxt = S_T0;
         S_T0:   state_nxt = Stop ? S_HALT : S_T1;
         S_T1:   state_nxt = MemDone ? S_T2 : S_T1W;
         S_T1W: begin
            if (MemDone)         state_nxt = S_T2;
            else if (mem_expire) state_nxt = S_HALT;
            else                 state_nxt = S_T1W;
         end
         S_T2:   state_nxt = S_T3;
         S_T3: begin
            // Illegal opcodes fall through to T0 exactly like nop.
            if (is_exec)      state_nxt = S_T4;
            else if (is_halt) state_nxt = S_HALT;
            else              state_nxt = S_T0;
         end
         S_T4:   state_nxt = S_T5;
         S_T5:   state_nxt = is_muldiv ? S_T6 : S_T0;
         S_T6:   state_nxt = S_T0;
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_RST;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output decode (from registered state and IR). T0 is the one exception:
   // a Stop request suppresses the fetch strobes in that same cycle so no PC
   // update happens on the way into HALT.
   // ---------------------------------------------------------------------------
   always_comb begin
      PCout    = 1'b0;
      MARin    = 1'b0;
      IncPC    = 1'b0;
      PCin     = 1'b0;
      Read     = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      ZLowin   = 1'b0;
      ZHighin  = 1'b0;
      ZLowout  = 1'b0;
      ZHighout = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      Gra      = 1'b0;
      Grb      = 1'b0;
      Grc      = 1'b0;
      Rin      = 1'b0;
      Rout     = 1'b0;
      OP       = '0;
      Run      = 1'b0;

      case (state)
         S_T0: begin
            Run = 1'b1;
            if (!Stop) begin
               PCout = 1'b1;
               MARin = 1'b1;
               IncPC = 1'b1;
            end
         end
         S_T1: begin
            Run   = 1'b1;
            PCin  = 1'b1;
            Read  = 1'b1;
            MDRin = 1'b1;
         end
         S_T1W: begin
            Run   = 1'b1;
            Read  = 1'b1;
            MDRin = 1'b1;
         end
         S_T2: begin
            Run    = 1'b1;
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            Run = 1'b1;
            // nop, halt and illegal opcodes must not disturb Y.
            if (is_exec) begin
               Grb  = 1'b1;
               Rout = 1'b1;
               Yin  = 1'b1;
            end
         end
         S_T4: begin
            Run     = 1'b1;
            Grc     = 1'b1;
            Rout    = 1'b1;
            ZLowin  = 1'b1;
            ZHighin = is_muldiv;
            OP      = opcode;
         end
         S_T5: begin
            Run     = 1'b1;
            ZLowout = 1'b1;
            if (is_muldiv) begin
               LOin = 1'b1;
            end else begin
               Gra = 1'b1;
               Rin = 1'b1;
            end
         end
         S_T6: begin
            Run      = 1'b1;
            ZHighout = 1'b1;
            HIin     = 1'b1;
         end
         default: begin
            // RST and HALT: everything idle.
         end
      endcase
   end

   assign State = state;

endmodule

// File: tb/tb_alu_seq_control.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_control
//
// Directed bench for alu_seq_control. Walks shl, add with memory wait, mul,
// an illegal opcode, an asynchronous Clear in T4, halt, a memory timeout and
// a Stop request, comparing every strobe, OP, Run, State and both flags each
// cycle against hand-written expectations.
// -----------------------------------------------------------------------------
module tb_alu_seq_control;

   // ---------------------------------------------------------------- clock/reset
   logic        Clock = 1'b0;
   logic        Clear;
   logic [31:0] IR;
   logic        MemDone;
   logic        Stop;

   always #5 Clock = ~Clock;

   logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
   logic Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin;
   logic Gra, Grb, Grc, Rin, Rout, Run, Illegal, Timeout;
   logic [4:0] OP;
   logic [3:0] State;

   alu_seq_control #(.OPW(5), .MEM_WAIT_MAX(15)) dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .MemDone(MemDone), .Stop(Stop),
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowin(ZLowin),
      .ZHighin(ZHighin), .ZLowout(ZLowout), .ZHighout(ZHighout), .HIin(HIin),
      .LOin(LOin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .OP(OP), .Run(Run), .Illegal(Illegal), .Timeout(Timeout), .State(State)
   );

   // Strobe bit positions in the packed observation vector.
   localparam int B_PCOUT = 19, B_MARIN = 18, B_INCPC = 17, B_PCIN = 16;
   localparam int B_READ = 15, B_MDRIN = 14, B_MDROUT = 13, B_IRIN = 12;
   localparam int B_YIN = 11, B_ZLOWIN = 10, B_ZHIGHIN = 9, B_ZLOWOUT = 8;
   localparam int B_ZHIGHOUT = 7, B_HIIN = 6, B_LOIN = 5, B_GRA = 4;
   localparam int B_GRB = 3, B_GRC = 2, B_RIN = 1, B_ROUT = 0;

   logic [19:0] strobes;
   assign strobes = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                     Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin,
                     Gra, Grb, Grc, Rin, Rout};

   localparam logic [19:0] M_NONE = 20'd0;
   localparam logic [19:0] M_T0   = (20'd1 << B_PCOUT) | (20'd1 << B_MARIN) | (20'd1 << B_INCPC);
   localparam logic [19:0] M_T1   = (20'd1 << B_PCIN) | (20'd1 << B_READ) | (20'd1 << B_MDRIN);
   localparam logic [19:0] M_T1W  = (20'd1 << B_READ) | (20'd1 << B_MDRIN);
   localparam logic [19:0] M_T2   = (20'd1 << B_MDROUT) | (20'd1 << B_IRIN);
   localparam logic [19:0] M_T3   = (20'd1 << B_GRB) | (20'd1 << B_ROUT) | (20'd1 << B_YIN);
   localparam logic [19:0] M_T4A  = (20'd1 << B_GRC) | (20'd1 << B_ROUT) | (20'd1 << B_ZLOWIN);
   localparam logic [19:0] M_T4M  = M_T4A | (20'd1 << B_ZHIGHIN);
   localparam logic [19:0] M_T5A  = (20'd1 << B_ZLOWOUT) | (20'd1 << B_GRA) | (20'd1 << B_RIN);
   localparam logic [19:0] M_T5M  = (20'd1 << B_ZLOWOUT) | (20'd1 << B_LOIN);
   localparam logic [19:0] M_T6   = (20'd1 << B_ZHIGHOUT) | (20'd1 << B_HIIN);

   localparam logic [3:0] ST_RST = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T1W = 4'd3;
   localparam logic [3:0] ST_T2 = 4'd4, ST_T3 = 4'd5, ST_T4 = 4'd6, ST_T5 = 4'd7;
   localparam logic [3:0] ST_T6 = 4'd8, ST_HALT = 4'd9;

   // shl  opcode 01010 Ra=1 Rb=3 Rc=5
   localparam logic [31:0] IR_SHL  = 32'h509A8000;
   // add  opcode 00011 Ra=2 Rb=3 Rc=4
   localparam logic [31:0] IR_ADD  = 32'h191A0000;
   // mul  opcode 01111 Ra=0 Rb=6 Rc=7
   localparam logic [31:0] IR_MUL  = 32'h78338000;
   localparam logic [31:0] IR_BAD  = 32'hF8000000;
   localparam logic [31:0] IR_HALT = 32'hD8000000;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------------------------------------------------------- checking
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [19:0] e_s, input logic [4:0] e_op,
                          input logic e_run, input logic [3:0] e_st,
                          input logic e_ill, input logic e_to);
      check({tag, ".strobes"}, {12'd0, strobes}, {12'd0, e_s});
      check({tag, ".op"},      {27'd0, OP},      {27'd0, e_op});
      check({tag, ".run"},     {31'd0, Run},     {31'd0, e_run});
      check({tag, ".state"},   {28'd0, State},   {28'd0, e_st});
      check({tag, ".illegal"}, {31'd0, Illegal}, {31'd0, e_ill});
      check({tag, ".timeout"}, {31'd0, Timeout}, {31'd0, e_to});
   endtask

   // Observe one cycle just after the falling edge.
   task automatic cyc(input string tag, input logic [19:0] e_s, input logic [4:0] e_op,
                      input logic e_run, input logic [3:0] e_st,
                      input logic e_ill, input logic e_to);
      @(negedge Clock);
      #1;
      chk_all(tag, e_s, e_op, e_run, e_st, e_ill, e_to);
   endtask

   // At most one bus driver in any cycle.
   always @(negedge Clock) begin
      vectors++;
      assert ($countones({PCout, MDRout, Rout, ZLowout, ZHighout}) <= 1)
      else begin
         miscompares++;
         $error("FAIL bus_excl observed=%b expected=onehot0",
                {PCout, MDRout, Rout, ZLowout, ZHighout});
      end
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      Clear   = 1'b1;
      IR      = IR_SHL;
      MemDone = 1'b1;
      Stop    = 1'b0;

      cyc("reset", M_NONE, 5'd0, 1'b0, ST_RST, 1'b0, 1'b0);
      Clear = 1'b0;

      // shl, memory ready immediately
      cyc("shl.T0", M_T0,  5'd0,       1'b1, ST_T0, 1'b0, 1'b0);
      cyc("shl.T1", M_T1,  5'd0,       1'b1, ST_T1, 1'b0, 1'b0);
      cyc("shl.T2", M_T2,  5'd0,       1'b1, ST_T2, 1'b0, 1'b0);
      cyc("shl.T3", M_T3,  5'd0,       1'b1, ST_T3, 1'b0, 1'b0);
      cyc("shl.T4", M_T4A, 5'b01010,   1'b1, ST_T4, 1'b0, 1'b0);
      cyc("shl.T5", M_T5A, 5'd0,       1'b1, ST_T5, 1'b0, 1'b0);

      // add, memory answers on the third wait cycle
      cyc("add.T0", M_T0, 5'd0, 1'b1, ST_T0, 1'b0, 1'b0);
      IR      = IR_ADD;
      MemDone = 1'b0;
      cyc("add.T1", M_T1, 5'd0, 1'b1, ST_T1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc($sformatf("add.T1W%0d", i), M_T1W, 5'd0, 1'b1, ST_T1W, 1'b0, 1'b0);
      end
      MemDone = 1'b1;
      cyc("add.T2", M_T2,  5'd0,     1'b1, ST_T2, 1'b0, 1'b0);
      cyc("add.T3", M_T3,  5'd0,     1'b1, ST_T3, 1'b0, 1'b0);
      cyc("add.T4", M_T4A, 5'b00011, 1'b1, ST_T4, 1'b0, 1'b0);
      cyc("add.T5", M_T5A, 5'd0,     1'b1, ST_T5, 1'b0, 1'b0);

      // mul
      cyc("mul.T0", M_T0, 5'd0, 1'b1, ST_T0, 1'b0, 1'b0);
      IR = IR_MUL;
      cyc("mul.T1", M_T1,  5'd0,     1'b1, ST_T1, 1'b0, 1'b0);
      cyc("mul.T2", M_T2,  5'd0,     1'b1, ST_T2, 1'b0, 1'b0);
      cyc("mul.T3", M_T3,  5'd0,     1'b1, ST_T3, 1'b0, 1'b0);
      cyc("mul.T4", M_T4M, 5'b01111, 1'b1, ST_T4, 1'b0, 1'b0);
      cyc("mul.T5", M_T5M, 5'd0,     1'b1, ST_T5, 1'b0, 1'b0);
      cyc("mul.T6", M_T6,  5'd0,     1'b1, ST_T6, 1'b0, 1'b0);

      // illegal opcode behaves as nop and raises Illegal
      cyc("ill.T0", M_T0, 5'd0, 1'b1, ST_T0, 1'b0, 1'b0);
      IR = IR_BAD;
      cyc("ill.T1",  M_T1,   5'd0, 1'b1, ST_T1, 1'b0, 1'b0);
      cyc("ill.T2",  M_T2,   5'd0, 1'b1, ST_T2, 1'b0, 1'b0);
      cyc("ill.T3",  M_NONE, 5'd0, 1'b1, ST_T3, 1'b0, 1'b0);
      cyc("ill.T0b", M_T0,   5'd0, 1'b1, ST_T0, 1'b1, 1'b0);

      // shl interrupted by Clear in the middle of T4
      IR = IR_SHL;
      cyc("clr.T1", M_T1,  5'd0,     1'b1, ST_T1, 1'b1, 1'b0);
      cyc("clr.T2", M_T2,  5'd0,     1'b1, ST_T2, 1'b1, 1'b0);
      cyc("clr.T3", M_T3,  5'd0,     1'b1, ST_T3, 1'b1, 1'b0);
      cyc("clr.T4", M_T4A, 5'b01010, 1'b1, ST_T4, 1'b1, 1'b0);
      #1;
      Clear = 1'b1;
      #1;
      chk_all("clr.async", M_NONE, 5'd0, 1'b0, ST_RST, 1'b0, 1'b0);
      cyc("clr.hold", M_NONE, 5'd0, 1'b0, ST_RST, 1'b0, 1'b0);
      Clear = 1'b0;

      // halt opcode
      cyc("halt.T0", M_T0, 5'd0, 1'b1, ST_T0, 1'b0, 1'b0);
      IR = IR_HALT;
      cyc("halt.T1", M_T1,   5'd0, 1'b1, ST_T1, 1'b0, 1'b0);
      cyc("halt.T2", M_T2,   5'd0, 1'b1, ST_T2, 1'b0, 1'b0);
      cyc("halt.T3", M_NONE, 5'd0, 1'b1, ST_T3, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc($sformatf("halt.H%0d", i), M_NONE, 5'd0, 1'b0, ST_HALT, 1'b0, 1'b0);
      end
      Clear = 1'b1;
      cyc("halt.clr", M_NONE, 5'd0, 1'b0, ST_RST, 1'b0, 1'b0);
      Clear = 1'b0;

      // memory never answers
      IR      = IR_SHL;
      MemDone = 1'b0;
      cyc("to.T0", M_T0, 5'd0, 1'b1, ST_T0, 1'b0, 1'b0);
      cyc("to.T1", M_T1, 5'd0, 1'b1, ST_T1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) begin
         cyc($sformatf("to.T1W%0d", i), M_T1W, 5'd0, 1'b1, ST_T1W, 1'b0, 1'b0);
      end
      cyc("to.halt", M_NONE, 5'd0, 1'b0, ST_HALT, 1'b0, 1'b1);
      Clear = 1'b1;
      cyc("to.clr", M_NONE, 5'd0, 1'b0, ST_RST, 1'b0, 1'b0);

      // Stop in T0: no fetch strobes, straight to HALT
      MemDone = 1'b1;
      Clear   = 1'b0;
      Stop    = 1'b1;
      cyc("stop.T0",   M_NONE, 5'd0, 1'b1, ST_T0,   1'b0, 1'b0);
      cyc("stop.halt", M_NONE, 5'd0, 1'b0, ST_HALT, 1'b0, 1'b0);
      Stop = 1'b0;
      cyc("stop.hold", M_NONE, 5'd0, 1'b0, ST_HALT, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
